// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control in front of the data-memory port; splits misaligned half/word
// accesses into byte beats when LSU_MISALIGN_SPLIT_EN is defined, otherwise rejects them with rsp_err.
module lsu_ctrl (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [2:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_wr_en,
   output logic [2:0]  mem_rw_type,
   output logic [31:0] mem_data_addr,
   output logic [31:0] mem_data_in,
   input  logic [31:0] mem_data_out
);
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam logic split_en = 1'b1;
`else
   localparam logic split_en = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, state_nxt;
   logic        wr_q, mis_q, err_q;
   logic [2:0]  type_q;
   logic [31:0] addr_q, wdata_q, asm_q, rdata_q;
   logic [1:0]  beat, last_q;
   logic        accept, req_mis, last, in_acc;
   logic [31:0] asm_nxt, ld_res;
   assign accept  = req_valid && req_ready;
   assign req_mis = (req_type[1] && req_addr[1:0] != 2'b00) || (req_type[1:0] == 2'b01 && req_addr[0]);
   assign last    = beat == last_q;
   assign in_acc  = state == ACCESS;
   always_ff @(posedge clk) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = !accept ? IDLE : (req_mis && !split_en) ? RESP : ACCESS;
         ACCESS:  state_nxt = last ? RESP : ACCESS;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end
   // Each beat owns a distinct byte lane, so the current byte simply overwrites its slot
   always_comb begin
      asm_nxt = asm_q;
      asm_nxt[{beat, 3'b000} +: 8] = mem_data_out[7:0];
      ld_res = !mis_q ? mem_data_out :
               type_q[1] ? asm_nxt :
               {type_q[2] ? 16'h0000 : {16{asm_nxt[15]}}, asm_nxt[15:0]};
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q    <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         type_q  <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         asm_q   <= 32'h0;
         rdata_q <= 32'h0;
         beat    <= 2'b00;
         last_q  <= 2'b00;
      end else if (accept) begin
         wr_q    <= req_wr;
         mis_q   <= req_mis;
         err_q   <= req_mis && !split_en;
         type_q  <= req_type;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         asm_q   <= 32'h0;
         rdata_q <= 32'h0;
         beat    <= 2'b00;
         last_q  <= !req_mis ? 2'd0 : req_type[1] ? 2'd3 : 2'd1;
      end else if (in_acc) begin
         beat  <= beat + 2'd1;
         asm_q <= asm_nxt;
         if (last)
            rdata_q <= wr_q ? 32'h0 : ld_res;
      end
   end
   // Write enable is cut by reset so a beat in flight at reset never commits
   always_comb begin
      req_ready     = state == IDLE;
      rsp_valid     = state == RESP;
      rsp_rdata     = rsp_valid ? rdata_q : 32'h0;
      rsp_err       = rsp_valid && err_q;
      mem_wr_en     = in_acc && wr_q && rstn;
      mem_rw_type   = !in_acc ? 3'b000 : mis_q ? 3'b100 : {type_q[2], type_q[1] ? 2'b10 : type_q[1:0]};
      mem_data_addr = in_acc ? addr_q + {30'h0, beat} : 32'h0;
      mem_data_in   = !in_acc ? 32'h0 : mis_q ? {24'h0, wdata_q[{beat, 3'b000} +: 8]} : wdata_q;
   end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: randomized and directed checks of lsu_ctrl against a byte-level memory reference model.
module tb_lsu_ctrl;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit split = 1'b1;
`else
   localparam bit split = 1'b0;
`endif
   logic        clk = 1'b0, rstn = 1'b0, req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
   logic [2:0]  req_type = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, rsp_valid, rsp_err, mem_wr_en;
   logic [2:0]  mem_rw_type;
   logic [31:0] rsp_rdata, mem_data_addr, mem_data_in, mem_data_out;
   int vectors = 0, miscompares = 0;
   logic [7:0] env_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];
   int unsigned mem_ver = 0;

   lsu_ctrl dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wr_en(mem_wr_en),
      .mem_rw_type(mem_rw_type), .mem_data_addr(mem_data_addr), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   function automatic int sz(logic [2:0] t);
      return t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
   endfunction

   function automatic logic [31:0] ext(logic [31:0] v, logic [2:0] t);
      if (sz(t) == 1) return t[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      if (sz(t) == 2) return t[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      return v;
   endfunction

   function automatic logic [7:0] env_byte(logic [31:0] a);
      return env_mem.exists(a) ? env_mem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_byte(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   // Memory the DUT talks to: combinational read, byte-granular write on posedge
   always @(mem_data_addr, mem_rw_type, mem_ver) begin
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < sz(mem_rw_type); i++) v[8*i +: 8] = env_byte(mem_data_addr + 32'(i));
      mem_data_out = ext(v, mem_rw_type);
   end

   always @(posedge clk) begin
      if (mem_wr_en) begin
         for (int i = 0; i < sz(mem_rw_type); i++) env_mem[mem_data_addr + 32'(i)] = mem_data_in[8*i +: 8];
         mem_ver = mem_ver + 1;
      end
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("rst_mem_wr_en", {31'h0, mem_wr_en}, 32'h0);
      chk("rst_mem_rw_type", {29'h0, mem_rw_type}, 32'h0);
      chk("rst_mem_addr", mem_data_addr, 32'h0);
      chk("rst_mem_data_in", mem_data_in, 32'h0);
   endtask

   task automatic xact(bit wr, logic [2:0] t, logic [31:0] a, logic [31:0] d, int hold);
      int n, beats, acc, wrs;
      bit mis, err;
      logic [31:0] exp_rd, v;
      n = sz(t);
      mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
      err = mis && !split;
      beats = err ? 0 : mis ? n : 1;
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 32'(i));
      exp_rd = (wr || err) ? 32'h0 : ext(v, t);
      if (wr && !err)
         for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1; req_wr = wr; req_type = t; req_addr = a; req_wdata = d;
      tick();
      req_valid = 1'b0;
      acc = 0;
      wrs = 0;
      while (!rsp_valid && acc < 8) begin
         chk("beat_addr", mem_data_addr, mis ? a + 32'(acc) : a);
         if (mis) chk("beat_type", {29'h0, mem_rw_type}, 32'h4);
         else if (t[1:0] != 2'b11) chk("beat_type", {29'h0, mem_rw_type}, {29'h0, t});
         if (wr) chk("beat_wdata", mem_data_in, mis ? {24'h0, d[8*acc +: 8]} : d);
         wrs += int'(mem_wr_en);
         acc++;
         tick();
      end
      chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("latency", acc, beats);
      chk("wr_beats", wrs, (wr && !err) ? beats : 0);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, err});
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_valid", {31'h0, rsp_valid}, 32'h1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_busy", {30'h0, req_ready, mem_wr_en}, 32'h0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("idle_after", {30'h0, rsp_valid, req_ready}, 32'h1);
      for (int i = 0; i < 4; i++) chk("mem_byte", {24'h0, env_byte(a + 32'(i))}, {24'h0, ref_byte(a + 32'(i))});
   endtask

   initial begin
      logic [31:0] bases [3];
      bases = '{32'h0000_0100, 32'h0000_01FC, 32'hFFFF_FFF8};
      tick();
      tick();
      chk_reset_outputs();
      rstn = 1'b1;
      tick();
      xact(1'b1, 3'b010, 32'h100, 32'h8899_AABB, 0);
      xact(1'b0, 3'b010, 32'h100, 32'h0, 0);
      xact(1'b1, 3'b010, 32'h103, 32'hDEAD_BEEF, 0);
      xact(1'b0, 3'b010, 32'h100, 32'h0, 0);
      xact(1'b0, 3'b010, 32'h104, 32'h0, 0);
      xact(1'b1, 3'b000, 32'h1FF, 32'h34, 0);
      xact(1'b1, 3'b000, 32'h200, 32'h92, 0);
      xact(1'b0, 3'b001, 32'h1FF, 32'h0, 0);
      xact(1'b0, 3'b101, 32'h1FF, 32'h0, 0);
      xact(1'b1, 3'b001, 32'h101, 32'h5A5A, 0);
      xact(1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0);
      xact(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0);
      xact(1'b0, 3'b010, 32'h100, 32'h0, 5);
      // Reset in the middle of a store: only the beats already completed may land
      req_valid = 1'b1; req_wr = 1'b1; req_type = 3'b010;
      req_addr = split ? 32'h203 : 32'h300; req_wdata = 32'h1122_3344;
      tick();
      req_valid = 1'b0;
      if (split) begin
         tick();
         tick();
         ref_mem[32'h203] = 8'h44;
         ref_mem[32'h204] = 8'h33;
      end
      rstn = 1'b0;
      tick();
      chk_reset_outputs();
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) chk("rst_mem_byte", {24'h0, env_byte(req_addr + 32'(i))}, {24'h0, ref_byte(req_addr + 32'(i))});
      tick();
      for (int k = 0; k < 150; k++)
         xact(1'($urandom), 3'($urandom), bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage sitting directly upstream of the data-memory port of the NPC's unified memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the memory's data-side signals (write enable, access type, address, write data). For misaligned halfword/word accesses it splits the request into sequential single-byte accesses. It returns the assembled, sign/zero-extended load result over a valid/ready response handshake.

## Interface
Parameters:
- none; datapath fixed at 32 bits, access-type encoding fixed (type[1:0]: 00 byte, 01 half, 10 word; type[2]: 1 = zero-extend, 0 = sign-extend)

Ports:
- clk  input  1  clock; all state updates on posedge
- rstn  input  1  reset, synchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_wr  input  1  1 = store, 0 = load
- req_type  input  3  access type per encoding above
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_rdata  output  32  extended load data; 0 for stores
- rsp_err  output  1  misaligned request rejected (only without split feature)
- mem_wr_en  output  1  to memory write enable
- mem_rw_type  output  3  to memory access type
- mem_data_addr  output  32  to memory address
- mem_data_in  output  32  to memory write data
- mem_data_out  input  32  from memory; combinational read of mem_data_addr, already extended per mem_rw_type

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready latch wr, type, addr, wdata; compute beat count N; clear beat counter and assembly register; go ACCESS.
- Aligned: byte always; half when addr[0]=0; word when addr[1:0]=00. N=1. Memory driven with latched type, addr, wdata; load result = mem_data_out captured directly.
- Misaligned: N=2 (half) or 4 (word). Beat k (k=0..N-1): mem_data_addr = addr+k (32-bit modulo, wraps FFFF_FFFF->0000_0000), mem_rw_type=3'b100, mem_data_in={24'b0, wdata[8k+7:8k]}, mem_wr_en=wr. Load: mem_data_out[7:0] captured into assembly[8k+7:8k].
- After last beat: misaligned load result = assembly extended per type[2] from bit 15 (half) or bit 31 (word, passthrough). Go RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid&&rsp_ready go IDLE.
- Store response: rsp_rdata=0.
- req_type[1:0]=11 treated as word.
- Outside ACCESS: mem_wr_en=0, mem_rw_type=0, mem_data_addr=0, mem_data_in=0.

## Timing
- Reset (rstn low at posedge): state IDLE, beat counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, all mem_* outputs 0. Applies mid-ACCESS; bytes already committed remain in memory, pending response is dropped.
- Request accepted at cycle T: ACCESS cycles T+1..T+N; rsp_valid asserted at T+N+1.
- Store bytes commit at the posedge ending each ACCESS cycle; exactly one mem_wr_en cycle per beat.
- Load data sampled in the same ACCESS cycle it is addressed.
- req_ready=0 in ACCESS and RESP; no request accepted in the cycle rsp handshake completes; next acceptance earliest one cycle later.
- Throughput: aligned back-to-back with rsp_ready=1 is one request per 3 cycles.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned requests split as above; rsp_err always 0.
- Undefined: misaligned request accepted but skips ACCESS (no mem_* activity, memory untouched); RESP entered at T+1 with rsp_err=1, rsp_rdata=0. Aligned behaviour unchanged.

## Test plan
- Aligned word load, addr 0x100, mem word 0x8899AABB, type 010 -> one ACCESS cycle with rw_type 010, rsp_valid at T+2, rsp_rdata=0x8899AABB, rsp_err=0.
- Misaligned word store 0xDEADBEEF at addr 0x103 (split on) -> 4 cycles mem_wr_en=1 at 0x103..0x106 with bytes EF,BE,AD,DE; subsequent word loads show byte 3 of 0x100 = EF, bytes 0..2 of 0x104 = BE,AD,DE.
- Misaligned signed half load at 0x1FF, bytes 0x1FF=0x34, 0x200=0x92 -> rsp_rdata=0xFFFF9234; same with type 101 -> 0x00009234.
- Address wrap: misaligned word load at 0xFFFFFFFE -> beat addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, no mem_wr_en; rsp_ready=1 -> IDLE next cycle.
- Reset asserted during beat 2 of misaligned store -> next cycle all outputs at reset values, only beats 0-1 committed; with LSU_MISALIGN_SPLIT_EN undefined, misaligned half at 0x101 -> rsp_err=1 at T+1, no mem_wr_en.
